// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the interconnect and its slave responders.
package wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_slv_state_t;

  // Expand byte selects into a per-bit mask over the data bus.
  function automatic logic [WB_DAT_W-1:0] wb_sel_mask(input logic [WB_SEL_W-1:0] sel);
    logic [WB_DAT_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < WB_SEL_W; b++) begin
      mask[8*b +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_ram_mem.sv
// Single-port DEPTH x 32 word memory with per-byte write enables and a registered read.
// The read register returns to zero on any cycle without a read.
module wb_ram_mem
  import wb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [AW-1:0]       idx_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic [WB_DAT_W-1:0] dat_i,
  output logic [WB_DAT_W-1:0] dat_o
);

  logic [WB_DAT_W-1:0] mem [DEPTH];
  logic [WB_DAT_W-1:0] mask;

  assign mask = wb_sel_mask(sel_i);

  // Contents are deliberately left untouched by reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[idx_i] <= (mem[idx_i] & ~mask) | (dat_i & mask);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_o <= '0;
    end else if (en_i && !we_i) begin
      dat_o <= mem[idx_i];
    end else begin
      dat_o <= '0;
    end
  end

endmodule

// File: rtl/wishbone_slave_ram.sv
// Wishbone B4 classic-cycle slave fronting a byte-writable word RAM with fixed wait states.
// Optional macro WB_RAM_ERR_EN: out-of-range or unaligned accesses terminate with err.
//
// state | meaning
// IDLE  | waiting for cyc & stb; request captured on accept
// WAIT  | wait-state down-counter running; cyc low aborts
// RESP  | ack or err driven for exactly one cycle
module wishbone_slave_ram
  import wb_pkg::*;
#(
  parameter int          TAGSIZE     = 1,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_DAT_W-1:0] ms_dat_i,
  input  logic [TAGSIZE-1:0]  ms_tgd_i,
  input  logic [31:0]         ms_adr_i,
  input  logic [TAGSIZE-1:0]  ms_tga_i,
  input  logic                ms_cyc_i,
  input  logic [TAGSIZE-1:0]  ms_tgc_i,
  input  logic [WB_SEL_W-1:0] ms_sel_i,
  input  logic                ms_stb_i,
  input  logic                ms_we_i,
  output logic [WB_DAT_W-1:0] sm_dat_o,
  output logic [TAGSIZE-1:0]  sm_tgd_o,
  output logic                sm_ack_o,
  output logic                sm_err_o,
  output logic                sm_rty_o
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_slv_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;
  logic          go_resp;

  logic [31:0]   offset;
  logic [AW-1:0] in_idx;
  logic          in_err;
  logic          unused_bits;

  logic                we_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [AW-1:0]       idx_q;
  logic [TAGSIZE-1:0]  tga_q;

  logic                cur_we;
  logic [WB_SEL_W-1:0] cur_sel;
  logic [WB_DAT_W-1:0] cur_dat;
  logic [AW-1:0]       cur_idx;
  logic [TAGSIZE-1:0]  cur_tga;
  logic                cur_err;

  logic                ack_q;
  logic [TAGSIZE-1:0]  tgd_q;
  logic                mem_en;

  assign offset      = ms_adr_i - BASE_ADDR;
  assign in_idx      = offset[AW+1:2];
  assign unused_bits = ^{offset, ms_tgd_i, ms_tgc_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (ms_cyc_i && ms_stb_i) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            go_resp = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!ms_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          go_resp = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live bus is used.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we  = ms_we_i;
      cur_sel = ms_sel_i;
      cur_dat = ms_dat_i;
      cur_idx = in_idx;
      cur_tga = ms_tga_i;
    end else begin
      cur_we  = we_q;
      cur_sel = sel_q;
      cur_dat = dat_q;
      cur_idx = idx_q;
      cur_tga = tga_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      tgd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= go_resp && !cur_err;
      tgd_q   <= go_resp ? cur_tga : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q  <= ms_we_i;
      sel_q <= ms_sel_i;
      dat_q <= ms_dat_i;
      idx_q <= in_idx;
      tga_q <= ms_tga_i;
    end
  end

`ifdef WB_RAM_ERR_EN
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  logic err_q;
  logic err_resp_q;

  assign in_err  = ({1'b0, offset} >= SPAN) || (ms_adr_i[1:0] != 2'b00);
  assign cur_err = (state_q == IDLE) ? in_err : err_q;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      err_q <= in_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_resp_q <= 1'b0;
    end else begin
      err_resp_q <= go_resp && cur_err;
    end
  end

  assign sm_err_o = err_resp_q;
`else
  assign in_err   = 1'b0;
  assign cur_err  = in_err;
  assign sm_err_o = 1'b0;
`endif

  // Reset on the commit edge suppresses the write along with the response.
  assign mem_en = go_resp && !cur_err && !rst_i;

  wb_ram_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (mem_en),
    .we_i  (cur_we),
    .idx_i (cur_idx),
    .sel_i (cur_sel),
    .dat_i (cur_dat),
    .dat_o (sm_dat_o)
  );

  assign sm_ack_o = ack_q;
  assign sm_tgd_o = tgd_q;
  assign sm_rty_o = 1'b0;

endmodule

// File: tb/tb_wishbone_slave_ram.sv
// Bench for wishbone_slave_ram: two instances (0 and 3 wait states) against a word-array model.
module tb_wishbone_slave_ram;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 256;
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc [2], stb [2], we [2], tga [2], tgd_in [2], tgc [2];
  logic [31:0] adr [2], wdat [2], rdat [2];
  logic [3:0]  sel [2];
  logic        tgo [2], ack [2], err [2], rty [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][DEPTH];

  wishbone_slave_ram #(.TAGSIZE(1), .DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut0 (
    .clk_i(clk), .rst_i(rst), .ms_dat_i(wdat[0]), .ms_tgd_i(tgd_in[0]), .ms_adr_i(adr[0]),
    .ms_tga_i(tga[0]), .ms_cyc_i(cyc[0]), .ms_tgc_i(tgc[0]), .ms_sel_i(sel[0]),
    .ms_stb_i(stb[0]), .ms_we_i(we[0]), .sm_dat_o(rdat[0]), .sm_tgd_o(tgo[0]),
    .sm_ack_o(ack[0]), .sm_err_o(err[0]), .sm_rty_o(rty[0]));

  wishbone_slave_ram #(.TAGSIZE(1), .DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut3 (
    .clk_i(clk), .rst_i(rst), .ms_dat_i(wdat[1]), .ms_tgd_i(tgd_in[1]), .ms_adr_i(adr[1]),
    .ms_tga_i(tga[1]), .ms_cyc_i(cyc[1]), .ms_tgc_i(tgc[1]), .ms_sel_i(sel[1]),
    .ms_stb_i(stb[1]), .ms_we_i(we[1]), .sm_dat_o(rdat[1]), .sm_tgd_o(tgo[1]),
    .sm_ack_o(ack[1]), .sm_err_o(err[1]), .sm_rty_o(rty[1]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return ERR_EN && ((off >= 32'(DEPTH * 4)) || (a[1:0] != 2'b00));
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off % 32'(DEPTH * 4)) / 32'd4);
  endfunction

  function automatic void mwrite(input int d, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] s);
    int i;
    if (is_err(a)) return;
    i = widx(a);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[d][i][8*b +: 8] = wd[8*b +: 8];
    end
  endfunction

  // One complete transfer; returns what was observed, the caller judges it.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic tg,
                      output int lat, output logic g_ack, output logic g_err,
                      output logic [31:0] rd, output logic g_tgd, output logic quiet);
    lat = 0; g_ack = 1'b0; g_err = 1'b0; rd = '0; g_tgd = 1'b0; quiet = 1'b0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd; sel[d] = s;
    tga[d] = tg; tgd_in[d] = 1'($urandom); tgc[d] = 1'($urandom);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        lat = n; g_ack = ack[d]; g_err = err[d]; rd = rdat[d]; g_tgd = tgo[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; adr[d] = $urandom; tga[d] = 1'b0;
    @(negedge clk);
    quiet = (ack[d] === 1'b0) && (err[d] === 1'b0) && (rdat[d] === 32'h0) &&
            (tgo[d] === 1'b0) && (rty[d] === 1'b0);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = BASE; wdat[d] = 32'h0;
      sel[d] = 4'hF; tga[d] = 1'b1; tgd_in[d] = 1'b0; tgc[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ack[d], err[d], rty[d], tgo[d], rdat[d]} !== 36'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got ack=%b err=%b rty=%b tgd=%b dat=%h want all 0",
                 d, ack[d], err[d], rty[d], tgo[d], rdat[d]);
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic a, e, t, q; logic [31:0] rd;
    xfer(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, a, e, rd, t, q);
    mwrite(0, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if ({lat, a, e, q} !== {32'd1, 3'b101}) begin
      errors++;
      $display("FAIL basic_write got lat=%0d ack=%b err=%b quiet=%b want lat=1 ack=1 err=0 quiet=1", lat, a, e, q);
    end
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if ({lat, a, e, q} !== {32'd1, 3'b101}) begin
      errors++;
      $display("FAIL basic_read_resp got lat=%0d ack=%b err=%b quiet=%b want lat=1 ack=1 err=0 quiet=1", lat, a, e, q);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_read_data got %h want deadbeef", rd);
    end
  endtask

  task automatic test_byte_enables();
    int lat; logic a, e, t, q; logic [31:0] rd;
    xfer(0, 1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, 1'b0, lat, a, e, rd, t, q);
    mwrite(0, BASE + 32'h10, 32'h11223344, 4'b0101);
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'h3, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if (rd !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL byte_sel_0101 got %h want de22be44", rd);
    end
    xfer(0, 1'b1, BASE + 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if ({lat, a, e} !== {32'd1, 2'b10}) begin
      errors++;
      $display("FAIL sel0_ack got lat=%0d ack=%b err=%b want lat=1 ack=1 err=0", lat, a, e);
    end
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if (rd !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL sel0_unchanged got %h want de22be44", rd);
    end
  endtask

  task automatic test_wait_states();
    int lat; logic a, e, t, q, seen; logic [31:0] rd;
    xfer(1, 1'b1, BASE + 32'h10, 32'hA5A55A5A, 4'hF, 1'b0, lat, a, e, rd, t, q);
    mwrite(1, BASE + 32'h10, 32'hA5A55A5A, 4'hF);
    xfer(1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b1, lat, a, e, rd, t, q);
    checks++;
    if ({lat, a, e, t, q} !== {32'd4, 4'b1011}) begin
      errors++;
      $display("FAIL ws3_read got lat=%0d ack=%b err=%b tgd=%b quiet=%b want lat=4 ack=1 err=0 tgd=1 quiet=1", lat, a, e, t, q);
    end
    checks++;
    if (rd !== 32'hA5A55A5A) begin
      errors++;
      $display("FAIL ws3_read_data got %h want a5a55a5a", rd);
    end
    // cyc dropped in cycle 2 aborts the write
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE + 32'h10;
    wdat[1] = 32'h12345678; sel[1] = 4'hF; tga[1] = 1'b0;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] || err[1]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resp got response=%b want 0", seen);
    end
    xfer(1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if (rd !== 32'hA5A55A5A) begin
      errors++;
      $display("FAIL abort_no_write got %h want a5a55a5a", rd);
    end
    // stb dropped in WAIT must not abort
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE + 32'h14;
    wdat[1] = 32'h0F0FF0F0; sel[1] = 4'hF;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    stb[1] = 1'b0;
    lat = 0;
    for (int n = 3; n <= 20; n++) begin
      @(negedge clk);
      if (ack[1]) begin lat = n; break; end
    end
    cyc[1] = 1'b0;
    mwrite(1, BASE + 32'h14, 32'h0F0FF0F0, 4'hF);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL stb_drop_ack got lat=%0d want 4", lat);
    end
    xfer(1, 1'b0, BASE + 32'h14, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if (rd !== 32'h0F0FF0F0) begin
      errors++;
      $display("FAIL stb_drop_write got %h want 0f0ff0f0", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, cnt, last, gap, want; logic a, e, t, q; logic [31:0] rd, wd;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        wd = $urandom;
        xfer(d, 1'b1, BASE + 32'h20 + 32'(4 * k), wd, 4'hF, 1'b0, lat, a, e, rd, t, q);
        mwrite(d, BASE + 32'h20 + 32'(4 * k), wd, 4'hF);
      end
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = BASE + 32'h20; sel[d] = 4'h0;
      cnt = 0; last = 0;
      for (int n = 1; n <= 80 && cnt < 4; n++) begin
        @(posedge clk); @(negedge clk);
        if (ack[d]) begin
          gap  = n - last;
          want = (cnt == 0) ? 1 + ws(d) : 2 + ws(d);
          checks++;
          if (gap !== want) begin
            errors++;
            $display("FAIL b2b_spacing dut%0d ack%0d got gap=%0d want %0d", d, cnt, gap, want);
          end
          checks++;
          if (rdat[d] !== model[d][8 + cnt]) begin
            errors++;
            $display("FAIL b2b_data dut%0d ack%0d got %h want %h", d, cnt, rdat[d], model[d][8 + cnt]);
          end
          last = n; cnt++;
          if (cnt == 4) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
          else adr[d] = BASE + 32'h20 + 32'(4 * cnt);
        end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      checks++;
      if (cnt !== 4) begin
        errors++;
        $display("FAIL b2b_count dut%0d got %0d acks want 4", d, cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_err_alias();
    int lat; logic a, e, t, q; logic [31:0] rd, want;
    xfer(0, 1'b1, BASE, 32'hCAFEF00D, 4'hF, 1'b0, lat, a, e, rd, t, q);
    mwrite(0, BASE, 32'hCAFEF00D, 4'hF);
    xfer(0, 1'b1, BASE + 32'h400, 32'h0BADBEEF, 4'hF, 1'b1, lat, a, e, rd, t, q);
    mwrite(0, BASE + 32'h400, 32'h0BADBEEF, 4'hF);
    checks++;
    if ({lat, a, e, t} !== {32'd1, !ERR_EN, ERR_EN, 1'b1}) begin
      errors++;
      $display("FAIL range_term got lat=%0d ack=%b err=%b tgd=%b want lat=1 ack=%b err=%b tgd=1", lat, a, e, t, !ERR_EN, ERR_EN);
    end
    want = ERR_EN ? 32'hCAFEF00D : 32'h0BADBEEF;
    xfer(0, 1'b0, BASE, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if (rd !== want) begin
      errors++;
      $display("FAIL range_word0 got %h want %h", rd, want);
    end
    xfer(0, 1'b0, BASE + 32'h2, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    want = ERR_EN ? 32'h0 : 32'h0BADBEEF;
    checks++;
    if ({a, e, rd} !== {!ERR_EN, ERR_EN, want}) begin
      errors++;
      $display("FAIL unaligned got ack=%b err=%b dat=%h want ack=%b err=%b dat=%h", a, e, rd, !ERR_EN, ERR_EN, want);
    end
    xfer(1, 1'b0, BASE + 32'h404, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if ({lat, a, e, q} !== {32'd4, !ERR_EN, ERR_EN, 1'b1}) begin
      errors++;
      $display("FAIL range_ws3 got lat=%0d ack=%b err=%b quiet=%b want lat=4 ack=%b err=%b quiet=1", lat, a, e, q, !ERR_EN, ERR_EN);
    end
  endtask

  task automatic test_reset_in_resp();
    int lat; logic a, e, t, q; logic [31:0] rd;
    xfer(1, 1'b1, BASE + 32'h14, 32'h77778888, 4'hF, 1'b0, lat, a, e, rd, t, q);
    mwrite(1, BASE + 32'h14, 32'h77778888, 4'hF);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE + 32'h14;
    wdat[1] = 32'h11110000; sel[1] = 4'hF; tga[1] = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({ack[1], err[1], rty[1], tgo[1], rdat[1]} !== 36'h0) begin
      errors++;
      $display("FAIL rst_resp_cycle got ack=%b err=%b tgd=%b dat=%h want all 0", ack[1], err[1], tgo[1], rdat[1]);
    end
    rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack[1], err[1], rty[1], tgo[1], rdat[1]} !== 36'h0) begin
      errors++;
      $display("FAIL rst_next_cycle got ack=%b err=%b tgd=%b dat=%h want all 0", ack[1], err[1], tgo[1], rdat[1]);
    end
    xfer(1, 1'b0, BASE + 32'h14, 32'h0, 4'h0, 1'b0, lat, a, e, rd, t, q);
    checks++;
    if (rd !== 32'h77778888) begin
      errors++;
      $display("FAIL rst_no_write got %h want 77778888", rd);
    end
  endtask

  task automatic test_random();
    int lat; logic a, e, t, q, w, tg, xe; logic [31:0] rd, ad, wd, want; logic [3:0] s;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) begin
        wd = $urandom;
        xfer(d, 1'b1, BASE + 32'(4 * k), wd, 4'hF, 1'b0, lat, a, e, rd, t, q);
        mwrite(d, BASE + 32'(4 * k), wd, 4'hF);
      end
      repeat (50) begin
        ad = BASE + 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 7) == 0) ad = ad + 32'h400 * 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) ad = ad + 32'($urandom_range(1, 3));
        w = 1'($urandom); wd = $urandom; s = 4'($urandom); tg = 1'($urandom);
        xe = is_err(ad);
        want = xe ? 32'h0 : model[d][widx(ad)];
        xfer(d, w, ad, wd, s, tg, lat, a, e, rd, t, q);
        checks++;
        if ({lat, a, e, t, q} !== {32'(1 + ws(d)), !xe, xe, tg, 1'b1}) begin
          errors++;
          $display("FAIL rand_resp dut%0d adr=%h got lat=%0d ack=%b err=%b tgd=%b quiet=%b want lat=%0d ack=%b err=%b tgd=%b quiet=1",
                   d, ad, lat, a, e, t, q, 1 + ws(d), !xe, xe, tg);
        end
        if (!w) begin
          checks++;
          if (rd !== want) begin
            errors++;
            $display("FAIL rand_read dut%0d adr=%h got %h want %h", d, ad, rd, want);
          end
        end else begin
          mwrite(d, ad, wd, s);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; tga[d] = 1'b0; tgd_in[d] = 1'b0;
      tgc[d] = 1'b0; adr[d] = '0; wdat[d] = '0; sel[d] = '0;
      for (int i = 0; i < DEPTH; i++) model[d][i] = 32'h0;
    end
    test_reset();
    test_basic();
    test_byte_enables();
    test_wait_states();
    test_back_to_back();
    test_err_alias();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
